store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: circular write buffer between the core's store port and dmem.
// Stores queue here and drain to dmem as it accepts them; loads get the port when it is free.
//
// Ports
//   clk, reset                  : clock; synchronous active-high reset
//   MemWrite, MemRead           : core store / load request
//   DataAdr, WriteData          : core byte address / store data
//   ReadData, Stall             : load data to the core / core must hold its request
//   MemWE, MemAdr, MemWD        : dmem write enable, address, write data
//   MemRD, MemReady             : dmem read data / dmem accepts the write at this edge
//
// Build option: define STORE_BUFFER_FWD_EN to forward buffered data to loads.
// Without it, a load waits until the buffer has fully drained.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemWE,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD,
    input  logic        MemReady
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];

    logic        full;
    logic        empty;
    logic        rd;
    logic        hit;
    logic [31:0] fwd_data;
    logic        load_port;
    logic        load_stall;
    logic        push;
    logic        drain;
    logic        pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A simultaneous store wins; the load is simply ignored.
    assign rd    = MemRead && !MemWrite;

`ifdef STORE_BUFFER_FWD_EN
    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (addr_q[head_q + PW'(i)] == DataAdr[31:2])) begin
                hit      = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    assign load_port  = rd && !hit;
    assign load_stall = 1'b0;
`else
    assign hit        = 1'b0;
    assign fwd_data   = '0;
    // No forwarding: a load may only see dmem once nothing is pending.
    assign load_port  = rd && empty;
    assign load_stall = rd && !empty;
`endif

    // Stall is from the current count; a drain on this edge does not lift it.
    assign Stall = (MemWrite && full) || load_stall;
    assign push  = MemWrite && !full;
    assign drain = !empty && !load_port;
    assign pop   = drain && MemReady;

    always_comb begin
        MemWE    = drain;
        MemAdr   = '0;
        MemWD    = '0;
        ReadData = '0;
        if (load_port) begin
            MemAdr   = DataAdr;
            ReadData = MemRD;
        end else if (drain) begin
            MemAdr = {addr_q[head_q], 2'b00};
            MemWD  = data_q[head_q];
        end
        if (rd && hit) begin
            ReadData = fwd_data;
        end
    end

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail_q] = DataAdr[31:2];
            data_d[tail_q] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer (DEPTH=4) against a small dmem model.
// Scenarios follow the default build; forwarding scenarios apply with STORE_BUFFER_FWD_EN.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemWE;
    logic [31:0] MemAdr;
    logic [31:0] MemWD;
    logic [31:0] MemRD;
    logic        MemReady;

    logic [31:0] dmem [256];

    int errs  = 0;
    int total = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Stall    (Stall),
        .MemWE    (MemWE),
        .MemAdr   (MemAdr),
        .MemWD    (MemWD),
        .MemRD    (MemRD),
        .MemReady (MemReady)
    );

    assign MemRD = dmem[MemAdr[9:2]];

    always @(posedge clk) begin
        if (MemWE && MemReady) dmem[MemAdr[9:2]] <= MemWD;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
        MemWrite  = w;
        MemRead   = r;
        DataAdr   = a;
        WriteData = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem[32]  = 32'h8080_8080;
        dmem[24]  = 32'h1234_5678;
        reset     = 1'b1;
        MemReady  = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        tick();
        tick();
        reset = 1'b0;
        drv(0, 0, 0, 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_we",    32'(MemWE), 0);
        chk("rst_adr",   MemAdr, 0);
        chk("rst_wd",    MemWD, 0);
        chk("rst_rd",    ReadData, 0);

        // in-order drain with dmem always ready
        MemReady = 1'b1;
        drv(1, 0, 32'h10, 32'h1111_0010);
        chk("st0_stall", 32'(Stall), 0);
        chk("st0_we",    32'(MemWE), 0);
        tick();
        drv(1, 0, 32'h14, 32'h1111_0014);
        chk("st1_we",    32'(MemWE), 1);
        chk("st1_adr",   MemAdr, 32'h10);
        chk("st1_wd",    MemWD, 32'h1111_0010);
        chk("st1_stall", 32'(Stall), 0);
        tick();
        drv(1, 0, 32'h18, 32'h1111_0018);
        chk("st2_adr", MemAdr, 32'h14);
        chk("st2_wd",  MemWD, 32'h1111_0014);
        tick();
        drv(0, 0, 0, 0);
        chk("st3_adr",   MemAdr, 32'h18);
        chk("st3_wd",    MemWD, 32'h1111_0018);
        chk("st3_stall", 32'(Stall), 0);
        tick();
        chk("st_empty_we",  32'(MemWE), 0);
        chk("st_empty_adr", MemAdr, 0);
        chk("st_dmem18",    dmem[6], 32'h1111_0018);

        // fill to DEPTH, fifth store stalls until one drain
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'h100 + 32'(4 * i), 32'hD000_0100 + 32'(4 * i));
            chk("fill_stall", 32'(Stall), 0);
            tick();
        end
        drv(1, 0, 32'h110, 32'hD000_0110);
        chk("full_stall", 32'(Stall), 1);
        chk("full_adr",   MemAdr, 32'h100);
        MemReady = 1'b1;
        #1;
        chk("full_drain_stall", 32'(Stall), 1);
        tick();
        MemReady = 1'b0;
        #1;
        chk("full_lift_stall", 32'(Stall), 0);
        chk("full_lift_adr",   MemAdr, 32'h104);
        tick();
        drv(0, 0, 0, 0);
        MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_dr_adr", MemAdr, 32'h104 + 32'(4 * i));
            chk("full_dr_wd",  MemWD, 32'hD000_0104 + 32'(4 * i));
            tick();
        end
        chk("full_empty_we", 32'(MemWE), 0);

        // store and load together: load is ignored
        drv(1, 1, 32'h60, 32'h6060_6060);
        chk("both_rd",    ReadData, 0);
        chk("both_adr",   MemAdr, 0);
        chk("both_we",    32'(MemWE), 0);
        chk("both_stall", 32'(Stall), 0);
        tick();
        drv(0, 0, 0, 0);
        chk("both_we1",  32'(MemWE), 1);
        chk("both_adr1", MemAdr, 32'h60);
        tick();

        // same word stores stay separate
        MemReady = 1'b0;
        drv(1, 0, 32'h300, 32'hA);
        tick();
        drv(1, 0, 32'h300, 32'hB);
        tick();
        MemReady = 1'b1;
        drv(0, 0, 0, 0);
        chk("same_wd0", MemWD, 32'hA);
        tick();
        chk("same_wd1", MemWD, 32'hB);
        tick();
        chk("same_we",   32'(MemWE), 0);
        chk("same_dmem", dmem[192], 32'hB);

`ifdef STORE_BUFFER_FWD_EN
        MemReady = 1'b0;
        drv(1, 0, 32'h20, 32'hAAAA_0000);
        tick();
        drv(1, 0, 32'h20, 32'hBBBB_0000);
        tick();
        drv(0, 1, 32'h22, 0);
        chk("fwd_rd",    ReadData, 32'hBBBB_0000);
        chk("fwd_stall", 32'(Stall), 0);
        chk("fwd_we",    32'(MemWE), 1);
        chk("fwd_adr",   MemAdr, 32'h20);
        MemReady = 1'b1;
        drv(0, 1, 32'h80, 0);
        chk("miss_adr",   MemAdr, 32'h80);
        chk("miss_we",    32'(MemWE), 0);
        chk("miss_stall", 32'(Stall), 0);
        chk("miss_rd",    ReadData, 32'h8080_8080);
        tick();
        drv(0, 0, 0, 0);
        chk("miss_res_we",  32'(MemWE), 1);
        chk("miss_res_adr", MemAdr, 32'h20);
        chk("miss_res_wd",  MemWD, 32'hAAAA_0000);
        tick();
        chk("miss_res_wd1", MemWD, 32'hBBBB_0000);
        tick();
        chk("miss_empty_we", 32'(MemWE), 0);
`else
        MemReady = 1'b0;
        drv(1, 0, 32'h40, 32'hCAFE_F00D);
        tick();
        drv(0, 1, 32'h40, 0);
        chk("ld_stall", 32'(Stall), 1);
        chk("ld_we",    32'(MemWE), 1);
        chk("ld_adr",   MemAdr, 32'h40);
        chk("ld_rd",    ReadData, 0);
        tick();
        chk("ld_hold_stall", 32'(Stall), 1);
        MemReady = 1'b1;
        #1;
        chk("ld_drain_stall", 32'(Stall), 1);
        tick();
        chk("ld_done_stall", 32'(Stall), 0);
        chk("ld_done_we",    32'(MemWE), 0);
        chk("ld_done_adr",   MemAdr, 32'h40);
        chk("ld_done_rd",    ReadData, 32'hCAFE_F00D);
        MemReady = 1'b0;
        drv(1, 0, 32'h44, 32'h4444);
        tick();
        drv(1, 0, 32'h48, 32'h4848);
        tick();
        drv(0, 1, 32'h80, 0);
        chk("miss_stall", 32'(Stall), 1);
        chk("miss_adr",   MemAdr, 32'h44);
        MemReady = 1'b1;
        tick();
        chk("miss_adr1", MemAdr, 32'h48);
        tick();
        chk("miss_stall_end", 32'(Stall), 0);
        chk("miss_adr_end",   MemAdr, 32'h80);
        chk("miss_rd",        ReadData, 32'h8080_8080);
        drv(0, 0, 0, 0);
`endif

        // reset discards pending entries
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 32'h200 + 32'(4 * i), 32'h5A00 + 32'(i));
            tick();
        end
        drv(0, 0, 0, 0);
        chk("rs_pend_we", 32'(MemWE), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_we",    32'(MemWE), 0);
        chk("rs_adr",   MemAdr, 0);
        chk("rs_stall", 32'(Stall), 0);
        MemReady = 1'b1;
        tick();
        tick();
        tick();
        chk("rs_idle_we", 32'(MemWE), 0);
        chk("rs_dmem0",   dmem[128], 0);
        chk("rs_dmem2",   dmem[130], 0);
        drv(1, 0, 32'h20C, 32'h77);
        tick();
        drv(0, 0, 0, 0);
        chk("rs_new_adr", MemAdr, 32'h20C);
        chk("rs_new_wd",  MemWD, 32'h77);
        tick();
        chk("rs_new_dmem", dmem[131], 32'h77);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
